player_ctrl: RTL and testbench

Converts button requests into audio-player control state. It merges four board push-buttons (active-low, asynchronous, bouncing) with the four active-low command strobes produced by the IR NEC decoder, and turns each press into a single event. It then tracks the play/pause state, the mute flag and the track index, and issues a one-cycle soft reset pulse. It sits directly downstream of the IR decoder and upstream of the audio playback datapath.

---
 rtl/player_pkg.sv | 16 +
 rtl/player_ctrl_key_debounce.sv | 53 +++++
 rtl/player_ctrl.sv | 150 +++++++++++++++
 tb/tb_player_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared encodings for the audio-player control block: player state codes
// and the button bit positions used by both the board keys and the IR strobes.
package player_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    localparam logic [1:0] BT_MUTE = 2'd0;
    localparam logic [1:0] BT_PLAY = 2'd1;
    localparam logic [1:0] BT_NEXT = 2'd2;
    localparam logic [1:0] BT_RST  = 2'd3;

    localparam int unsigned NUM_BT = 4;

endpackage

// File: rtl/player_ctrl_key_debounce.sv
// One board key: 2-flop synchronizer, stability counter, debounced level
// (1 = pressed) and a one-cycle strobe on the released-to-pressed transition.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pressed;

    assign w_pressed = ~r_sync2;

    // Level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (w_pressed != r_level) begin
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_level <= w_pressed;
                    r_press <= w_pressed;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/player_ctrl.sv
// Audio-player control: merges debounced board keys and IR strobes into events
// driving play/pause state, mute, track index and a soft-reset strobe.
// Optional next-key auto-repeat is built when HOLD_REPEAT_EN is defined.
module player_ctrl #(
    parameter int unsigned DEB_CYCLES    = 1_000_000,
    parameter int unsigned NUM_TRACKS    = 4,
    parameter int unsigned TRACK_W       = 2,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         key_n,
    input  logic [3:0]         ir_bt_n,
    output logic [1:0]         state,
    output logic               mute,
    output logic [TRACK_W-1:0] track,
    output logic               track_pulse,
    output logic               soft_rst
);

    import player_pkg::*;

    if ((2 ** TRACK_W) < NUM_TRACKS) begin : g_bad_track_w
        $error("TRACK_W too narrow for NUM_TRACKS");
    end
    if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_hold
        $error("HOLD_CYCLES and REPEAT_CYCLES must be nonzero");
    end

    logic [NUM_BT-1:0]  w_level;
    logic [NUM_BT-1:0]  w_press;
    logic [NUM_BT-1:0]  w_ir_ev;
    logic [NUM_BT-1:0]  w_ev;
    logic [NUM_BT-1:0]  r_ir_prev;
    logic               w_rep;
    logic               w_unused_level;

    logic [1:0]         r_state,  w_state_nxt;
    logic               r_mute,   w_mute_nxt;
    logic [TRACK_W-1:0] r_track,  w_track_nxt;
    logic               r_tp,     w_tp_nxt;
    logic               r_srst,   w_srst_nxt;

    for (genvar g = 0; g < NUM_BT; g++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_key_n (key_n[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    assign w_unused_level = ^w_level;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_repeating;

    // Counter holds cycles since the last next event while the key stays down.
    assign w_rep = w_level[BT_NEXT] & ~w_press[BT_NEXT] &
                   (r_repeating ? (r_hold_cnt == HOLD_W'(REPEAT_CYCLES))
                                : (r_hold_cnt == HOLD_W'(HOLD_CYCLES)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end else if (!w_level[BT_NEXT]) begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end else if (w_press[BT_NEXT] || w_rep) begin
            r_hold_cnt  <= HOLD_W'(1);
            r_repeating <= w_rep;
        end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign w_rep = 1'b0;
`endif

    // IR strobes are already synchronous: falling edge against last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ir_prev <= '1;
        else     r_ir_prev <= ir_bt_n;
    end

    assign w_ir_ev = r_ir_prev & ~ir_bt_n;

    always_comb begin
        w_ev          = w_press | w_ir_ev;
        w_ev[BT_NEXT] = w_ev[BT_NEXT] | w_rep;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mute  <= 1'b0;
            r_track <= '0;
            r_tp    <= 1'b0;
            r_srst  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mute  <= w_mute_nxt;
            r_track <= w_track_nxt;
            r_tp    <= w_tp_nxt;
            r_srst  <= w_srst_nxt;
        end
    end

    // Reset event wins outright; otherwise mute, play and next all apply.
    always_comb begin
        w_state_nxt = r_state;
        w_mute_nxt  = r_mute;
        w_track_nxt = r_track;
        w_tp_nxt    = 1'b0;
        w_srst_nxt  = 1'b0;
        if (w_ev[BT_RST]) begin
            w_state_nxt = ST_IDLE;
            w_mute_nxt  = 1'b0;
            w_track_nxt = '0;
            w_tp_nxt    = (r_track != '0);
            w_srst_nxt  = 1'b1;
        end else begin
            if (w_ev[BT_MUTE]) w_mute_nxt = ~r_mute;
            case (r_state)
                ST_IDLE:    if (w_ev[BT_PLAY]) w_state_nxt = ST_PLAYING;
                ST_PLAYING: if (w_ev[BT_PLAY]) w_state_nxt = ST_PAUSED;
                ST_PAUSED:  if (w_ev[BT_PLAY]) w_state_nxt = ST_PLAYING;
                default:    w_state_nxt = ST_IDLE;
            endcase
            if (w_ev[BT_NEXT]) begin
                w_track_nxt = (r_track == TRACK_W'(NUM_TRACKS - 1)) ? '0 : r_track + TRACK_W'(1);
                w_tp_nxt    = 1'b1;
            end
        end
    end

    assign state       = r_state;
    assign mute        = r_mute;
    assign track       = r_track;
    assign track_pulse = r_tp;
    assign soft_rst    = r_srst;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: IR vector table, board-key sequences,
// hold/repeat (HOLD_REPEAT_EN aware) and randomized IR traffic vs. a rule model.
module tb_player_ctrl;

    localparam int unsigned DEB  = 8;
    localparam int unsigned NT   = 3;
    localparam int unsigned TW   = 2;
    localparam int unsigned HOLD = 40;
    localparam int unsigned REP  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    key_n;
    logic [3:0]    ir_bt_n;
    logic [1:0]    state;
    logic          mute;
    logic [TW-1:0] track;
    logic          track_pulse;
    logic          soft_rst;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] ir;
        int         s;
        int         m;
        int         t;
        int         tp;
        int         sr;
    } vec_t;

    vec_t tbl[12];

    player_ctrl #(
        .DEB_CYCLES    (DEB),
        .NUM_TRACKS    (NT),
        .TRACK_W       (TW),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .ir_bt_n     (ir_bt_n),
        .state       (state),
        .mute        (mute),
        .track       (track),
        .track_pulse (track_pulse),
        .soft_rst    (soft_rst)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int pack(input int s, input int m, input int t, input int tp, input int sr);
        return (s << 5) | (m << 4) | (t << 2) | (tp << 1) | sr;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int exp);
        int act;
        act = pack(int'(state), int'(mute), int'(track), int'(track_pulse), int'(soft_rst));
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got {st,mu,tr,tp,sr}=%02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ir_pulse(input logic [3:0] v);
        ir_bt_n = v;
        tick();
        ir_bt_n = 4'hF;
        tick();
    endtask

    initial begin
        int toggles;
        int tog_at;
        logic last_mute;
        int pulses[$];
        int exp_pulses;
        int ms, mm, mt, mtp, msr;
        logic [3:0] prev, cur, ev;

        tbl[0]  = '{4'b1101, 1, 0, 0, 0, 0};
        tbl[1]  = '{4'b1101, 2, 0, 0, 0, 0};
        tbl[2]  = '{4'b1101, 1, 0, 0, 0, 0};
        tbl[3]  = '{4'b1011, 1, 0, 1, 1, 0};
        tbl[4]  = '{4'b1011, 1, 0, 2, 1, 0};
        tbl[5]  = '{4'b1011, 1, 0, 0, 1, 0};
        tbl[6]  = '{4'b1011, 1, 0, 1, 1, 0};
        tbl[7]  = '{4'b1110, 1, 1, 1, 0, 0};
        tbl[8]  = '{4'b1000, 2, 0, 2, 1, 0};
        tbl[9]  = '{4'b0111, 0, 0, 0, 1, 1};
        tbl[10] = '{4'b0111, 0, 0, 0, 0, 1};
        tbl[11] = '{4'b0000, 0, 0, 0, 0, 1};

        rst     = 1'b1;
        key_n   = 4'hF;
        ir_bt_n = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset_values", pack(0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();

        // Asynchronous reset between edges
        ir_pulse(4'b1101);
        ir_pulse(4'b1110);
        ir_pulse(4'b1011);
        chk_out("pre_async_reset", pack(1, 1, 1, 0, 0));
        #2 rst = 1'b1;
        #1 chk_out("async_reset", pack(0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            ir_bt_n = tbl[i].ir;
            tick();
            chk_out($sformatf("vec%0d", i), pack(tbl[i].s, tbl[i].m, tbl[i].t, tbl[i].tp, tbl[i].sr));
            ir_bt_n = 4'hF;
            tick();
            chk_out($sformatf("vec%0d_idle", i), pack(tbl[i].s, tbl[i].m, tbl[i].t, 0, 0));
        end

        // Sustained IR low gives a single play event
        ir_bt_n = 4'b1101;
        tick();
        chk_out("ir_hold_first", pack(1, 0, 0, 0, 0));
        repeat (3) tick();
        chk_out("ir_hold_sustained", pack(1, 0, 0, 0, 0));
        ir_bt_n = 4'hF;
        tick();

        // Board bounce on mute key, then a clean hold
        for (int c = 0; c < 30; c++) begin
            key_n[0] = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        key_n[0]  = 1'b0;
        toggles   = 0;
        tog_at    = -1;
        last_mute = mute;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mute != last_mute) begin
                toggles++;
                if (tog_at < 0) tog_at = k;
            end
            last_mute = mute;
        end
        chk("bounce_toggle_count", toggles, 1);
        chk("bounce_toggle_edge", tog_at, 10);
        key_n[0] = 1'b1;
        repeat (30) tick();
        chk_out("board_release_no_event", pack(1, 1, 0, 0, 0));

        // Simultaneous reset (IR) and board mute with track=2
        ir_pulse(4'b1110);
        ir_pulse(4'b1011);
        ir_pulse(4'b1011);
        key_n[0] = 1'b0;
        tick();
        repeat (9) tick();
        chk_out("simul_before", pack(1, 0, 2, 0, 0));
        ir_bt_n = 4'b0111;
        tick();
        chk_out("simul_reset", pack(0, 0, 0, 1, 1));
        ir_bt_n = 4'hF;
        tick();
        chk_out("simul_after", pack(0, 0, 0, 0, 0));
        key_n[0] = 1'b1;
        repeat (20) tick();

        // Board next held 100 cycles
        key_n[2] = 1'b0;
        for (int c = 0; c < 140; c++) begin
            if (c == 100) key_n[2] = 1'b1;
            tick();
            if (track_pulse) pulses.push_back(c);
        end
`ifdef HOLD_REPEAT_EN
        exp_pulses = 5;
`else
        exp_pulses = 1;
`endif
        chk("hold_pulse_count", pulses.size(), exp_pulses);
        chk("hold_final_track", int'(track), exp_pulses % NT);
`ifdef HOLD_REPEAT_EN
        if (pulses.size() == 5) begin
            chk("hold_rep1", pulses[1] - pulses[0], 40);
            chk("hold_rep2", pulses[2] - pulses[0], 56);
            chk("hold_rep3", pulses[3] - pulses[0], 72);
            chk("hold_rep4", pulses[4] - pulses[0], 88);
        end
`endif

        // Randomized IR traffic against the rule model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        ms = 0; mm = 0; mt = 0;
        prev = 4'hF;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) cur[b] = ($urandom_range(0, 3) != 0);
            ir_bt_n = cur;
            tick();
            ev  = prev & ~cur;
            mtp = 0;
            msr = 0;
            if (ev[3]) begin
                mtp = (mt != 0) ? 1 : 0;
                msr = 1;
                ms  = 0;
                mt  = 0;
                mm  = 0;
            end else begin
                if (ev[0]) mm = 1 - mm;
                if (ev[1]) ms = (ms == 1) ? 2 : 1;
                if (ev[2]) begin
                    mt  = (mt + 1) % NT;
                    mtp = 1;
                end
            end
            prev = cur;
            chk_out($sformatf("rand%0d", c), pack(ms, mm, mt, mtp, msr));
        end
        ir_bt_n = 4'hF;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
